// File: rtl/cache_arbiter.sv
// cache_arbiter
// Shares the single-ported unified cache between the instruction-fetch port (I)
// and the load/store port (D). A granted request is latched into the c_* registers,
// held until the cache pulses c_ready, then reported with a one-cycle done pulse.
// Optional feature macro: CACHE_ARB_DPRIO_EN gives D fixed priority on simultaneous
// requests; without it, simultaneous requests are served round-robin.
module cache_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic              d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              c_en,
  output logic              c_we,
  output logic              c_byte,
  output logic [ADDR_W-1:0] c_addr,
  output logic [31:0]       c_wdata,
  input  logic [31:0]       c_rdata,
  input  logic              c_ready,
  output logic              busy,
  output logic              grant_d,
  output logic              timeout_err
);

  localparam int              WD_W    = $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            win_d;
  logic            accept;
  logic [WD_W-1:0] wd_cnt;

  assign accept = (state == IDLE) && (i_req || d_req);

`ifdef CACHE_ARB_DPRIO_EN
  // D takes every request it makes; I is served only when D is quiet
  always_comb begin
    win_d = d_req;
  end
`else
  logic last_d;

  // A lone requester wins; on a tie the port not granted last time wins
  always_comb begin
    win_d = d_req & (~i_req | ~last_d);
  end

  // Remember who completed last; reset points at I so the first tie goes to D
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_d <= 1'b0;
    end else if (state == BUSY && c_ready) begin
      last_d <= grant_d;
    end
  end
`endif

  // State register; reset abandons any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus handshake outputs; c_en drops in the c_ready cycle so the cache never restarts
  always_comb begin
    state_next = state;
    c_en       = 1'b0;
    busy       = 1'b0;
    i_done     = 1'b0;
    d_done     = 1'b0;
    case (state)
      IDLE: begin
        if (i_req || d_req) state_next = BUSY;
      end
      BUSY: begin
        busy = 1'b1;
        c_en = ~c_ready;
        if (c_ready) state_next = RESP;
      end
      RESP: begin
        busy       = 1'b1;
        i_done     = ~grant_d;
        d_done     = grant_d;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the winning request so requesters may change their inputs after the grant
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_d <= 1'b0;
      c_we    <= 1'b0;
      c_byte  <= 1'b0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else if (accept) begin
      grant_d <= win_d;
      c_we    <= win_d & d_we;
      c_byte  <= win_d & d_byte;
      c_addr  <= win_d ? d_addr : i_addr;
      c_wdata <= win_d ? d_wdata : '0;
    end
  end

  // Capture read data for the owning port; stores leave both result registers alone
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      i_rdata <= '0;
      d_rdata <= '0;
    end else if (state == BUSY && c_ready && !c_we) begin
      if (grant_d) begin
        d_rdata <= c_rdata;
      end else begin
        i_rdata <= c_rdata;
      end
    end
  end

  // Watchdog: saturating count of BUSY cycles, sticky flag once the limit is reached
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
    end else if (accept) begin
      wd_cnt <= '0;
    end else if (state == BUSY) begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_LAST) timeout_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter
// Randomised scoreboard bench for cache_arbiter. A transaction-level model decides
// which port is served next and what each port's read result must be; a monitor
// pops those expectations whenever the DUT pulses a done. A small cache model
// answers after an address-dependent number of enabled cycles.
// Build with CACHE_ARB_DPRIO_EN defined to check the fixed-priority variant.
module tb_cache_arbiter;

`ifdef CACHE_ARB_DPRIO_EN
  localparam bit DPRIO = 1'b1;
`else
  localparam bit DPRIO = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req;
  logic        d_we;
  logic        d_byte;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        c_en;
  logic        c_we;
  logic        c_byte;
  logic [31:0] c_addr;
  logic [31:0] c_wdata;
  logic [31:0] c_rdata;
  logic        c_ready;
  logic        busy;
  logic        grant_d;
  logic        timeout_err;

  cache_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .i_req       (i_req),
    .i_addr      (i_addr),
    .i_rdata     (i_rdata),
    .i_done      (i_done),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_byte      (d_byte),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_done      (d_done),
    .c_en        (c_en),
    .c_we        (c_we),
    .c_byte      (c_byte),
    .c_addr      (c_addr),
    .c_wdata     (c_wdata),
    .c_rdata     (c_rdata),
    .c_ready     (c_ready),
    .busy        (busy),
    .grant_d     (grant_d),
    .timeout_err (timeout_err)
  );

  typedef struct {
    bit          port_d;
    bit          we;
    bit          byt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] i_rdata;
    logic [31:0] d_rdata;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // cache model state
  logic        ready_m;
  logic        stray;
  bit          hang;
  int          en_cnt;
  logic [31:0] cap_addr;
  logic        cap_we;
  logic        cap_byte;
  logic [31:0] cap_wdata;

  // transaction-level reference state
  bit          m_last_d;
  logic [31:0] m_i_rdata;
  logic [31:0] m_d_rdata;
  bit          i_pend;
  bit          d_pend;
  logic [31:0] hi_addr;
  bit          hd_we;
  bit          hd_byte;
  logic [31:0] hd_addr;
  logic [31:0] hd_wdata;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cache contents: a fixed function of the address, with the documented fetch word at 0x40
  function automatic logic [31:0] data_of(input logic [31:0] a);
    if (a == 32'h0000_0040) return 32'h8FA2_0004;
    return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
  endfunction

  // enabled cycles before c_ready: hits take 2, addresses with bit 3 set miss for up to 14
  function automatic int lat_of(input logic [31:0] a);
    if (a[3]) return 2 + (int'(a[7:4]) % 13);
    return 2;
  endfunction

  assign c_rdata = ready_m ? data_of(c_addr) : 32'hDEAD_BEEF;
  assign c_ready = ready_m | stray;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_state();
    check_bit("rst_busy", busy, 1'b0);
    check_bit("rst_i_done", i_done, 1'b0);
    check_bit("rst_d_done", d_done, 1'b0);
    check_bit("rst_c_en", c_en, 1'b0);
    check_bit("rst_c_we", c_we, 1'b0);
    check_bit("rst_c_byte", c_byte, 1'b0);
    check_bit("rst_grant_d", grant_d, 1'b0);
    check_bit("rst_timeout_err", timeout_err, 1'b0);
    check_word("rst_c_addr", c_addr, 32'h0);
    check_word("rst_c_wdata", c_wdata, 32'h0);
    check_word("rst_i_rdata", i_rdata, 32'h0);
    check_word("rst_d_rdata", d_rdata, 32'h0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b0;
    i_req     = 1'b0;
    d_req     = 1'b0;
    hang      = 1'b0;
    stray     = 1'b0;
    i_pend    = 1'b0;
    d_pend    = 1'b0;
    m_last_d  = 1'b0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    exp_q.delete();
    #1;
    check_reset_state();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic apply_stimulus_i(input logic [31:0] a);
    i_pend  = 1'b1;
    hi_addr = a;
    i_req   = 1'b1;
    i_addr  = a;
  endtask

  task automatic apply_stimulus_d(input bit we, input bit byt, input logic [31:0] a,
                                  input logic [31:0] wd);
    d_pend   = 1'b1;
    hd_we    = we;
    hd_byte  = byt;
    hd_addr  = a;
    hd_wdata = wd;
    d_req    = 1'b1;
    d_we     = we;
    d_byte   = byt;
    d_addr   = a;
    d_wdata  = wd;
  endtask

  task automatic scramble(input bit w);
    if (w) begin
      d_addr  = $urandom;
      d_wdata = $urandom;
      d_we    = 1'($urandom);
      d_byte  = 1'($urandom);
    end else begin
      i_addr = $urandom;
    end
  endtask

  task automatic restore(input bit w);
    if (w) begin
      d_addr  = hd_addr;
      d_we    = hd_we;
      d_byte  = hd_byte;
      d_wdata = hd_wdata;
    end else begin
      i_addr = hi_addr;
    end
  endtask

  // Decide the next served port from the held requests, push its expectation, wait for its done.
  // Must be called on a falling edge while the arbiter is idle or in its response cycle.
  task automatic serve(input bit reissue, output bit won_d, output int took);
    exp_t e;
    bit   w;
    bit   got;
    if (i_pend && d_pend) w = DPRIO ? 1'b1 : ~m_last_d;
    else w = d_pend;
    m_last_d = w;
    e.port_d = w;
    if (w) begin
      e.we    = hd_we;
      e.byt   = hd_byte;
      e.addr  = hd_addr;
      e.wdata = hd_wdata;
      if (!hd_we) m_d_rdata = data_of(hd_addr);
    end else begin
      e.we      = 1'b0;
      e.byt     = 1'b0;
      e.addr    = hi_addr;
      e.wdata   = '0;
      m_i_rdata = data_of(hi_addr);
    end
    e.i_rdata = m_i_rdata;
    e.d_rdata = m_d_rdata;
    exp_q.push_back(e);
    got  = 1'b0;
    took = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) scramble(w);
      if (w ? d_done : i_done) begin
        got  = 1'b1;
        took = k;
      end
    end
    check_bit("done_seen", got, 1'b1);
    if (got) begin
      if (reissue) begin
        restore(w);
      end else if (w) begin
        d_req  = 1'b0;
        d_pend = 1'b0;
      end else begin
        i_req  = 1'b0;
        i_pend = 1'b0;
      end
    end else begin
      do_reset();
    end
    won_d = w;
  endtask

  // Idle gap with a stray c_ready pulse that the arbiter must ignore
  task automatic idle_gap();
    @(negedge clk);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check_bit("stray_ready_busy", busy, 1'b0);
    @(negedge clk);
    check_bit("stray_ready_idle", busy, 1'b0);
  endtask

  // Cache model: counts enabled cycles, raises c_ready for one full cycle after the latency
  initial begin
    ready_m = 1'b0;
    en_cnt  = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        en_cnt = 0;
      end else if (c_en) begin
        if (en_cnt == 0) begin
          cap_addr  = c_addr;
          cap_we    = c_we;
          cap_byte  = c_byte;
          cap_wdata = c_wdata;
        end
        en_cnt++;
        if (!hang && en_cnt == lat_of(c_addr)) begin
          @(posedge clk);
          #1 ready_m = 1'b1;
          @(negedge clk);
          check_bit("c_en_during_ready", c_en, 1'b0);
          @(posedge clk);
          #1 ready_m = 1'b0;
          en_cnt = 0;
        end
      end
    end
  end

  // Monitor: every done must match the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (i_done || d_done)) begin
        check_bit("done_onehot", i_done & d_done, 1'b0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_done: got i_done=%b d_done=%b expected no done at %0t",
                   i_done, d_done, $time);
        end else begin
          e = exp_q.pop_front();
          check_bit("done_port", d_done, e.port_d);
          check_bit("grant_d", grant_d, e.port_d);
          check_bit("c_en_in_resp", c_en, 1'b0);
          check_word("c_addr", cap_addr, e.addr);
          check_bit("c_we", cap_we, e.we);
          check_bit("c_byte", cap_byte, e.byt);
          check_word("c_wdata", cap_wdata, e.wdata);
          check_word("i_rdata", i_rdata, e.i_rdata);
          check_word("d_rdata", d_rdata, e.d_rdata);
        end
      end
    end
  end

  // Global time limit so the run always ends
  initial begin
    #500000;
    $display("[TB] FAIL sim_time_limit: got no finish expected finish before %0t", $time);
    $fatal(1, "[TB] time limit");
  end

  // Directed scenarios first, then randomised traffic, then the watchdog
  initial begin
    bit w;
    int took;
    reset   = 1'b0;
    i_req   = 1'b0;
    i_addr  = '0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_byte  = 1'b0;
    d_addr  = '0;
    d_wdata = '0;
    stray   = 1'b0;
    hang    = 1'b0;
    i_pend  = 1'b0;
    d_pend  = 1'b0;
    m_last_d  = 1'b0;
    m_i_rdata = '0;
    m_d_rdata = '0;
    repeat (2) @(negedge clk);
    check_reset_state();
    reset = 1'b1;

    // fetch hit at 0x40: done in the cycle after E+3
    apply_stimulus_i(32'h0000_0040);
    serve(1'b0, w, took);
    check_word("hit_latency", 32'(took), 32'd3);

    // both requests held continuously: D,I,D,I round-robin or all D with priority
    apply_stimulus_i(32'h0000_0080);
    apply_stimulus_d(1'b0, 1'b0, 32'h0000_0090, 32'h0);
    for (int k = 0; k < 4; k++) begin
      serve(1'b1, w, took);
      check_bit("tie_grant", grant_d, DPRIO ? 1'b1 : ((k % 2) == 0));
    end
    while (i_pend || d_pend) serve(1'b0, w, took);

    // byte store: c_we/c_byte set, d_rdata untouched
    apply_stimulus_d(1'b1, 1'b1, 32'h0000_0101, 32'h1122_33AB);
    serve(1'b0, w, took);

    // load miss with writeback: 14 enabled cycles
    @(negedge clk);
    apply_stimulus_d(1'b0, 1'b0, 32'h0000_00C8, 32'h0);
    serve(1'b0, w, took);
    check_word("miss_latency", 32'(took), 32'd15);
    check_bit("miss_no_timeout", timeout_err, 1'b0);

    // randomised traffic with reissues and idle gaps
    for (int t = 0; t < 150; t++) begin
      if (!i_pend && $urandom_range(0, 1) == 1) apply_stimulus_i($urandom);
      if (!d_pend && $urandom_range(0, 1) == 1)
        apply_stimulus_d(1'($urandom), 1'($urandom), $urandom, $urandom);
      if (!i_pend && !d_pend) apply_stimulus_i($urandom);
      serve($urandom_range(0, 3) == 0, w, took);
      if (!i_pend && !d_pend && $urandom_range(0, 3) == 0) idle_gap();
    end
    while (i_pend || d_pend) serve(1'b0, w, took);

    // cache never answers: flag sets on the 64th BUSY edge and stays, no done
    @(negedge clk);
    hang   = 1'b1;
    i_req  = 1'b1;
    i_addr = 32'h0000_0200;
    @(posedge clk);
    repeat (63) @(posedge clk);
    #1;
    check_bit("timeout_before_limit", timeout_err, 1'b0);
    check_bit("c_en_while_hung", c_en, 1'b1);
    @(posedge clk);
    #1;
    check_bit("timeout_at_limit", timeout_err, 1'b1);
    repeat (20) @(posedge clk);
    #1;
    check_bit("timeout_sticky", timeout_err, 1'b1);
    check_bit("busy_while_hung", busy, 1'b1);
    do_reset();

    // recovery after reset
    apply_stimulus_i(32'h0000_0040);
    serve(1'b0, w, took);
    check_bit("post_reset_timeout", timeout_err, 1'b0);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check_word("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
